conv1_calc: RTL and testbench
=============================

Name: conv1_calc

Overview:
- Consumes the 5x5 window and window-valid strobe from the conv1 line/window buffer and computes OUT_CH parallel 5x5 convolutions per valid window.
- Each channel result passes through bias add, arithmetic right shift, ReLU and saturation to DATA_BITS.
- Fully pipelined: one window per clock, 4-cycle latency.
- Feeds the conv1 max-pool stage. Asserts a per-frame done pulse after the last output of each 24x24 output map.

Parameters:
- DATA_BITS, 8, pixel, weight and bias width (signed).
- OUT_CH, 3, number of output channels (filters).
- SHIFT, 7, arithmetic right shift applied to each accumulator before bias add.
- OUT_PER_FRAME, 576, valid outputs per frame (24x24).
- ACC_BITS, 2*DATA_BITS+5, accumulator width (holds the sum of 25 products).

Ports:
- clk, in, 1, clock.
- rst_n, in, 1, reset, synchronous, active-low.
- valid_in, in, 1, window valid from the window buffer.
- win_in, in, 25*DATA_BITS, signed window; element k at [k*DATA_BITS +: DATA_BITS]. k=0 is top-left (oldest row, oldest column); k=24 is newest pixel.
- w_we, in, 1, coefficient write enable.
- w_addr, in, $clog2(OUT_CH*26), coefficient address: c*26+k. k=0..24 is weight k of channel c; k=25 is bias of channel c.
- w_data, in, DATA_BITS, signed coefficient.
- conv_out, out, OUT_CH*DATA_BITS, channel c at [c*DATA_BITS +: DATA_BITS], range 0..2^(DATA_BITS-1)-1.
- valid_out, out, 1, conv_out valid.
- frame_done, out, 1, one-cycle pulse coincident with the OUT_PER_FRAME-th valid_out.

Behaviour:
- Reset: all coefficient registers = 0, conv_out = 0, valid_out = 0, frame_done = 0, output counter = 0, all pipeline valid bits = 0. Reset mid-frame discards in-flight windows; no valid_out for 4 cycles after rst_n deasserts.
- Coefficient write: on w_we, the register at w_addr takes w_data at the clock edge. It is used by any window entering stage 1 on a later cycle.
- Write collision: a write in the same cycle as valid_in means stage 1 uses the old value.
- Out-of-range w_addr (>= OUT_CH*26): ignored.
- S1: register 25*OUT_CH signed products win[k]*w[c][k], each 2*DATA_BITS wide.
- S2: per channel, register 5 partial sums, each the sum of products k=5r..5r+4, at ACC_BITS width.
- S3: per channel, register acc = sum of the 5 partials, then (acc >>> SHIFT) + sign-extended bias, at ACC_BITS+1 width.
- S4: per channel, ReLU and saturate.
  - Value < 0 gives 0.
  - Value > 2^(DATA_BITS-1)-1 gives 2^(DATA_BITS-1)-1.
  - Otherwise the value is passed through.
  - Result is registered to conv_out.
- Valid propagates through a 4-deep shift register. valid_out is asserted exactly 4 cycles after valid_in.
- Back-to-back windows give back-to-back outputs; bubbles on the input are preserved on the output.
- conv_out holds its last value when valid_out = 0.
- Output counter increments on each valid_out and wraps to 0 after OUT_PER_FRAME-1. frame_done = 1 on the cycle the counter is at OUT_PER_FRAME-1 with valid_out = 1.
- No backpressure: the downstream stage accepts every valid_out.

Decomposition:
- Shared package conv_pkg:
  - DATA_BITS, KERNEL=5, KAREA=25.
  - Derived ACC_BITS.
  - Function sat_relu(value, bits).
  - Coefficient address constants (BIAS_OFS=25, CH_STRIDE=26).
- One sub-module, conv1_mac5x5: a single-channel S1–S3 pipeline taking the window, 25 weights and a bias, and producing the pre-saturation sum.
  - conv1_calc instantiates it OUT_CH times.
  - conv1_calc owns the coefficient registers, the S4 saturation, the valid pipe and the frame counter.

Test Plan:
- Load channel 0 with all weights 1 and bias 0; instance with SHIFT=0. Apply one window of all 1s with valid_in pulse at cycle T -> valid_out at T+4, conv_out ch0 = 25; ch1 and ch2 = 0 (reset coefficients).
- Default SHIFT=7; ch1 weights all 127, bias 0; window all 127 -> acc 403225, >>>7 = 3150 -> saturates, ch1 = 127. Same with window all -128 and weights 127 -> ch1 = 0 (ReLU).
- SHIFT=0; ch2 weights 0, bias -3 -> ch2 = 0. Bias 5 -> ch2 = 5. Change bias to 9 via write on the same cycle as valid_in -> that window gives 5 and the next window gives 9.
- 10 consecutive valid windows with ramp pixel value k, then 3 idle cycles, then 2 more windows -> 12 valid_out pulses with identical spacing, values match the reference model, conv_out held during the gap.
- Stream 576 valid windows -> frame_done pulses once, on output 576 only. Stream 576 more -> second pulse; the counter wraps.
- Assert rst_n=0 for one cycle while 3 windows are in flight -> no valid_out for those windows; outputs and coefficients return to 0; frame counter restarts (frame_done after 576 new outputs).

Source files
------------

// File: rtl/conv_pkg.sv
// Shared constants and helpers for the conv1 convolution datapath.
package conv_pkg;
    localparam int DATA_BITS = 8;
    localparam int KERNEL    = 5;
    localparam int KAREA     = KERNEL * KERNEL;
    localparam int ACC_BITS  = 2 * DATA_BITS + 5;
    localparam int SUM_BITS  = ACC_BITS + 1;
    localparam int BIAS_OFS  = 25;
    localparam int CH_STRIDE = 26;

    // Clamp a biased, shifted sum into the unsigned half of a signed DATA_BITS word.
    function automatic logic [DATA_BITS-1:0] sat_relu(input logic signed [SUM_BITS-1:0] value,
                                                      input int bits);
        logic signed [SUM_BITS-1:0] max_val;
        max_val = SUM_BITS'((1 << (bits - 1)) - 1);
        if (value[SUM_BITS-1]) return '0;
        if (value > max_val) return max_val[DATA_BITS-1:0];
        return value[DATA_BITS-1:0];
    endfunction
endpackage

// File: rtl/conv1_mac5x5.sv
// Single-channel 5x5 multiply-accumulate: products, row partial sums, then
// shifted total plus bias. Three register stages, no reset on the datapath.
module conv1_mac5x5 #(
    parameter int DATA_BITS = 8,
    parameter int ACC_BITS  = 2 * DATA_BITS + 5,
    parameter int SHIFT     = 7
) (
    input  logic                                 clk,
    input  logic [conv_pkg::KAREA*DATA_BITS-1:0] win,
    input  logic [conv_pkg::KAREA*DATA_BITS-1:0] weights,
    input  logic signed [DATA_BITS-1:0]          bias,
    output logic signed [ACC_BITS:0]             sum
);
    import conv_pkg::KERNEL, conv_pkg::KAREA;

    localparam int PROD_BITS = 2 * DATA_BITS;
    localparam int OUT_BITS  = ACC_BITS + 1;

    logic signed [PROD_BITS-1:0] prod   [KAREA];
    logic signed [ACC_BITS-1:0]  psum_d [KERNEL];
    logic signed [ACC_BITS-1:0]  psum   [KERNEL];
    logic signed [ACC_BITS-1:0]  acc;
    logic signed [DATA_BITS-1:0] bias_s1;
    logic signed [DATA_BITS-1:0] bias_s2;

    always_ff @(posedge clk) begin
        for (int k = 0; k < KAREA; k++) begin
            prod[k] <= PROD_BITS'($signed(win[k*DATA_BITS +: DATA_BITS]))
                     * PROD_BITS'($signed(weights[k*DATA_BITS +: DATA_BITS]));
        end
        bias_s1 <= bias;
    end

    always_comb begin
        for (int r = 0; r < KERNEL; r++) begin
            psum_d[r] = '0;
            for (int j = 0; j < KERNEL; j++) begin
                psum_d[r] = psum_d[r] + ACC_BITS'(prod[r*KERNEL + j]);
            end
        end
    end

    // Bias travels with its window so a later coefficient write cannot reach it.
    always_ff @(posedge clk) begin
        psum    <= psum_d;
        bias_s2 <= bias_s1;
    end

    always_comb begin
        acc = '0;
        for (int r = 0; r < KERNEL; r++) begin
            acc = acc + psum[r];
        end
    end

    always_ff @(posedge clk) begin
        sum <= OUT_BITS'(acc >>> SHIFT) + OUT_BITS'(bias_s2);
    end
endmodule

// File: rtl/conv1_calc.sv
// conv1 compute stage: OUT_CH parallel 5x5 convolutions with bias, shift,
// ReLU and saturation; 4-cycle latency, one window per clock.
module conv1_calc #(
    parameter int DATA_BITS     = 8,
    parameter int OUT_CH        = 3,
    parameter int SHIFT         = 7,
    parameter int OUT_PER_FRAME = 576,
    parameter int ACC_BITS      = 2 * DATA_BITS + 5
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic                                          valid_in,
    input  logic [conv_pkg::KAREA*DATA_BITS-1:0]          win_in,
    input  logic                                          w_we,
    input  logic [$clog2(OUT_CH*conv_pkg::CH_STRIDE)-1:0] w_addr,
    input  logic signed [DATA_BITS-1:0]                   w_data,
    output logic [OUT_CH*DATA_BITS-1:0]                   conv_out,
    output logic                                          valid_out,
    output logic                                          frame_done
);
    import conv_pkg::*;

    localparam int NCOEF = OUT_CH * CH_STRIDE;
    localparam int CNT_W = $clog2(OUT_PER_FRAME);

    logic signed [DATA_BITS-1:0]       coef   [NCOEF];
    logic [KAREA*DATA_BITS-1:0]        ch_w   [OUT_CH];
    logic signed [DATA_BITS-1:0]       ch_b   [OUT_CH];
    logic signed [ACC_BITS:0]          ch_sum [OUT_CH];
    logic [3:0]                        vpipe;
    logic [CNT_W-1:0]                  out_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NCOEF; i++) coef[i] <= '0;
        end else if (w_we && (int'(w_addr) < NCOEF)) begin
            coef[w_addr] <= w_data;
        end
    end

    always_comb begin
        for (int c = 0; c < OUT_CH; c++) begin
            ch_w[c] = '0;
            for (int k = 0; k < KAREA; k++) begin
                ch_w[c][k*DATA_BITS +: DATA_BITS] = coef[c*CH_STRIDE + k];
            end
            ch_b[c] = coef[c*CH_STRIDE + BIAS_OFS];
        end
    end

    for (genvar c = 0; c < OUT_CH; c++) begin : g_ch
        conv1_mac5x5 #(
            .DATA_BITS (DATA_BITS),
            .ACC_BITS  (ACC_BITS),
            .SHIFT     (SHIFT)
        ) u_mac (
            .clk     (clk),
            .win     (win_in),
            .weights (ch_w[c]),
            .bias    (ch_b[c]),
            .sum     (ch_sum[c])
        );
    end

    // vpipe[2] marks a valid sum in the mac output register; S4 captures it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vpipe    <= '0;
            conv_out <= '0;
        end else begin
            vpipe <= {vpipe[2:0], valid_in};
            if (vpipe[2]) begin
                for (int c = 0; c < OUT_CH; c++) begin
                    conv_out[c*DATA_BITS +: DATA_BITS] <= sat_relu(ch_sum[c], DATA_BITS);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_cnt <= '0;
        end else if (valid_out) begin
            if (out_cnt == CNT_W'(OUT_PER_FRAME - 1)) out_cnt <= '0;
            else                                      out_cnt <= out_cnt + 1'b1;
        end
    end

    assign valid_out  = vpipe[3];
    assign frame_done = valid_out && (out_cnt == CNT_W'(OUT_PER_FRAME - 1));
endmodule

// File: tb/tb_conv1_calc.sv
// Bench for conv1_calc: SHIFT=0 and SHIFT=7 instances share stimulus and are
// checked each cycle against an arithmetic reference plus hand-computed vectors.
module tb_conv1_calc;
    localparam int NCOEF = 78;
    localparam int FRAME = 576;

    logic              clk = 1'b0;
    logic              rst_n, valid_in, w_we;
    logic [199:0]      win_in;
    logic [6:0]        w_addr;
    logic signed [7:0] w_data;
    logic [23:0]       co0, co7;
    logic              vo0, vo7, fd0, fd7;

    conv1_calc #(.SHIFT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .win_in(win_in),
        .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
        .conv_out(co0), .valid_out(vo0), .frame_done(fd0));

    conv1_calc #(.SHIFT(7)) dut7 (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .win_in(win_in),
        .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
        .conv_out(co7), .valid_out(vo7), .frame_done(fd7));

    always #5 clk = ~clk;

    typedef struct { int due; logic [23:0] v0; logic [23:0] v7; } exp_t;
    typedef struct { int ch; int wt; int bias; int pix; int e0; int e7; } vec_t;

    exp_t        q[$];
    vec_t        vecs[7];
    int          mc[NCOEF];
    logic [23:0] last0 = '0, last7 = '0;
    int total = 0, bad = 0, cyc = 0, out_cnt = 0;
    int outs_seen = 0, pulses = 0, pulse_at = 0, base = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Direct sum of products per channel, then shift, bias and clamp to 0..127.
    function automatic logic [23:0] ref_out(input int shift);
        logic [23:0] r;
        int acc, v;
        r = '0;
        for (int c = 0; c < 3; c++) begin
            acc = 0;
            for (int k = 0; k < 25; k++)
                acc += int'($signed(win_in[k*8 +: 8])) * mc[c*26 + k];
            v = (acc >>> shift) + mc[c*26 + 25];
            if (v < 0) v = 0;
            if (v > 127) v = 127;
            r[c*8 +: 8] = v[7:0];
        end
        return r;
    endfunction

    task automatic tick();
        exp_t e;
        logic ev, fd_exp;
        if (!rst_n) begin
            q.delete();
            for (int i = 0; i < NCOEF; i++) mc[i] = 0;
            out_cnt = 0;
            last0 = '0;
            last7 = '0;
        end else begin
            if (valid_in) begin
                e.due = cyc + 4;
                e.v0  = ref_out(0);
                e.v7  = ref_out(7);
                q.push_back(e);
            end
            if (w_we && int'(w_addr) < NCOEF) mc[w_addr] = int'(w_data);
        end
        @(posedge clk);
        #1;
        cyc++;
        while (q.size() > 0 && q[0].due < cyc) void'(q.pop_front());
        ev = (q.size() > 0 && q[0].due == cyc);
        fd_exp = 1'b0;
        if (ev) begin
            e = q.pop_front();
            last0 = e.v0;
            last7 = e.v7;
            fd_exp = (out_cnt == FRAME - 1);
            out_cnt = (out_cnt + 1) % FRAME;
        end
        chk("valid_out s0", {31'b0, vo0}, {31'b0, ev});
        chk("valid_out s7", {31'b0, vo7}, {31'b0, ev});
        chk("frame_done s0", {31'b0, fd0}, {31'b0, fd_exp});
        chk("frame_done s7", {31'b0, fd7}, {31'b0, fd_exp});
        chk("conv_out s0", {8'b0, co0}, {8'b0, last0});
        chk("conv_out s7", {8'b0, co7}, {8'b0, last7});
        if (vo0 === 1'b1) begin
            outs_seen++;
            if (fd0 === 1'b1) begin
                pulses++;
                pulse_at = outs_seen;
            end
        end
    endtask

    task automatic write_coef(input int addr, input int data);
        w_we   = 1'b1;
        w_addr = 7'(addr);
        w_data = 8'(data);
        tick();
        w_we   = 1'b0;
    endtask

    task automatic load_ch(input int ch, input int wt, input int b);
        for (int k = 0; k < 25; k++) write_coef(ch*26 + k, wt);
        write_coef(ch*26 + 25, b);
    endtask

    task automatic set_win_const(input int p);
        for (int k = 0; k < 25; k++) win_in[k*8 +: 8] = 8'(p);
    endtask

    task automatic set_win_rand();
        for (int k = 0; k < 25; k++) win_in[k*8 +: 8] = 8'($urandom);
    endtask

    task automatic load_rand();
        for (int a = 0; a < NCOEF; a++) write_coef(a, int'($urandom_range(0, 255)) - 128);
    endtask

    task automatic stream(input int n);
        for (int i = 0; i < n; i++) begin
            set_win_rand();
            valid_in = 1'b1;
            tick();
        end
        valid_in = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        //            ch  wt   bias pix   s0   s7
        vecs[0] = '{0,   1,   0,   1,  25,   0};
        vecs[1] = '{1, 127,   0, 127, 127, 127};
        vecs[2] = '{1, 127,   0, -128,  0,   0};
        vecs[3] = '{2,   0,  -3,   5,   0,   0};
        vecs[4] = '{2,   0,   5,   5,   5,   5};
        vecs[5] = '{0,  -2, 100,   3,   0,  98};
        vecs[6] = '{1,   4,  -1,   1,  99,   0};

        rst_n = 1'b0; valid_in = 1'b0; w_we = 1'b0;
        w_addr = '0; w_data = '0; win_in = '0;
        idle(2);
        rst_n = 1'b1;
        chk("reset conv_out", {8'b0, co0}, 32'd0);
        chk("reset valid_out", {31'b0, vo0}, 32'd0);
        chk("reset frame_done", {31'b0, fd0}, 32'd0);

        for (int i = 0; i < 7; i++) begin
            load_ch(vecs[i].ch, vecs[i].wt, vecs[i].bias);
            set_win_const(vecs[i].pix);
            valid_in = 1'b1;
            tick();
            valid_in = 1'b0;
            for (int t = 0; t < 2; t++) begin
                tick();
                chk("vec early valid", {31'b0, vo0}, 32'd0);
            end
            tick();
            chk("vec valid at T+4", {31'b0, vo0}, 32'd1);
            chk("vec s0 value", {24'b0, co0[vecs[i].ch*8 +: 8]}, 32'(vecs[i].e0));
            chk("vec s7 value", {24'b0, co7[vecs[i].ch*8 +: 8]}, 32'(vecs[i].e7));
            if (i == 0) begin
                chk("vec reset ch1", {24'b0, co0[15:8]}, 32'd0);
                chk("vec reset ch2", {24'b0, co0[23:16]}, 32'd0);
            end
            idle(1);
        end

        // bias write in the same cycle as a window only affects the next window
        set_win_const(5);
        w_we = 1'b1; w_addr = 7'd77; w_data = 8'sd9;
        valid_in = 1'b1;
        tick();
        w_we = 1'b0;
        tick();
        valid_in = 1'b0;
        idle(2);
        chk("collision old bias", {24'b0, co0[23:16]}, 32'd5);
        tick();
        chk("collision new bias", {24'b0, co0[23:16]}, 32'd9);
        idle(2);

        write_coef(100, 55);
        write_coef(127, -1);
        set_win_const(1);
        valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
        idle(4);

        load_rand();
        base = outs_seen;
        for (int j = 0; j < 12; j++) begin
            if (j == 10) begin
                valid_in = 1'b0;
                idle(3);
            end
            for (int k = 0; k < 25; k++) win_in[k*8 +: 8] = 8'(k + j - 12);
            valid_in = 1'b1;
            tick();
        end
        valid_in = 1'b0;
        idle(6);
        chk("ramp output count", 32'(outs_seen - base), 32'd12);

        for (int i = 0; i < 300; i++) begin
            valid_in = ($urandom_range(0, 9) < 6);
            set_win_rand();
            w_we   = ($urandom_range(0, 3) == 0);
            w_addr = 7'($urandom_range(0, 127));
            w_data = 8'($urandom);
            tick();
        end
        valid_in = 1'b0; w_we = 1'b0;
        idle(5);

        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        load_rand();
        base = outs_seen; pulses = 0; pulse_at = 0;
        stream(FRAME);
        idle(5);
        chk("frame1 pulses", 32'(pulses), 32'd1);
        chk("frame1 pulse index", 32'(pulse_at - base), 32'(FRAME));
        stream(FRAME);
        idle(5);
        chk("frame2 pulses", 32'(pulses), 32'd2);
        chk("frame2 pulse index", 32'(pulse_at - base), 32'(2 * FRAME));

        stream(100);
        rst_n = 1'b0;
        stream(100);
        valid_in = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        base = outs_seen; pulses = 0; pulse_at = 0;
        idle(4);
        chk("midreset no outputs", 32'(outs_seen - base), 32'd0);
        chk("midreset conv_out s0", {8'b0, co0}, 32'd0);
        chk("midreset conv_out s7", {8'b0, co7}, 32'd0);
        stream(FRAME);
        idle(5);
        chk("post-reset pulses", 32'(pulses), 32'd1);
        chk("post-reset pulse index", 32'(pulse_at - base), 32'(FRAME));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
